// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Imported by the round-robin selector and the arbiter top.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side handshake bundle for one arbiter port.
// The requester holds the master modport and the arbiter holds the slave modport.
interface ram_arb_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin winner select with its priority pointer.
// The pointer moves only when the arbiter accepts a request.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       winner
);

    logic rr_ptr;

    // The pointer only matters when both ports are asking at once.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        winner = PORT0;
        if (req[0] && req[1]) begin
            winner = rr_ptr;
        end else if (req[1]) begin
            winner = PORT1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
        if (!rst_n) begin
            rr_ptr <= PORT0;
        end else if (advance) begin
            rr_ptr <= ~winner;
        end
    end

endmodule

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with a shared tri-state data bus.
// Writes commit on posedge; reads load on the negedge and drive the bus while oe is high.
module single_port_sync_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_en;

    assign rd_en = cs && oe && !we;

    // NOTE: the storage array has no reset; its contents survive a system reset, like a real RAM.
    always_ff @(posedge clk) begin
        if (cs && we) begin
            mem[addr] <= data;
        end
    end

    always_ff @(negedge clk) begin
        if (rd_en) begin
            rd_q <= mem[addr];
        end
    end

    assign data = rd_en ? rd_q : 'z;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port RAM between two requesters.
// Each access runs IDLE -> ACCESS -> DONE; this block owns every RAM pin and the bus direction.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arb_if.slave              p0,
    ram_arb_if.slave              p1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    arb_state_t            state, state_d;
    logic                  start;
    logic                  winner;
    logic                  win_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  bus_drive;
    logic [1:0]            gnt_q;
    logic [1:0]            rvalid_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    ram_arb_rr2 u_rr2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({p1.req, p0.req}),
        .advance (start),
        .winner  (winner)
    );

    assign sel_we    = (winner == PORT1) ? p1.we    : p0.we;
    assign sel_addr  = (winner == PORT1) ? p1.addr  : p0.addr;
    assign sel_wdata = (winner == PORT1) ? p1.wdata : p0.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (p0.req || p1.req) begin
                    state_d = ACCESS;
                    start   = 1'b1;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM pins are registered; the async reset drops cs immediately, aborting any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= PORT0;
            wdata_q   <= '0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            bus_drive <= 1'b0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_q         <= winner;
                        wdata_q       <= sel_wdata;
                        ram_addr      <= sel_addr;
                        ram_cs        <= 1'b1;
                        ram_we        <= sel_we;
                        ram_oe        <= ~sel_we;
                        bus_drive     <= sel_we;
                        gnt_q[winner] <= 1'b1;
                    end
                end
                ACCESS: begin
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_oe    <= 1'b0;
                    bus_drive <= 1'b0;
                    // The RAM has been driving the bus since the mid-cycle negedge.
                    if (!ram_we) begin
                        rvalid_q[win_q] <= 1'b1;
                        if (win_q == PORT1) begin
                            rdata1_q <= ram_data;
                        end else begin
                            rdata0_q <= ram_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_data = bus_drive ? wdata_q : 'z;

    assign p0.gnt    = gnt_q[0];
    assign p1.gnt    = gnt_q[1];
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomised checks of ram_port_arbiter driving a single_port_sync_ram.
// Expected values come from hand-computed constants and a reference memory model.
module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    wire  [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;

    ram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
    ram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0       (p0_if),
        .p1       (p1_if),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe)
    );

    single_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram (
        .clk  (clk),
        .cs   (ram_cs),
        .we   (ram_we),
        .oe   (ram_oe),
        .addr (ram_addr),
        .data (ram_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [logic [AW-1:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Continuous protocol checks: one-hot grants/rvalids, and no contention on the bus.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_onehot", 32'(p0_if.gnt && p1_if.gnt), 32'd0);
            check("rvalid_onehot", 32'(p0_if.rvalid && p1_if.rvalid), 32'd0);
            check("bus_contention", 32'(ram_oe && dut.bus_drive), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    function automatic logic get_gnt(input int port);
        return (port == 0) ? p0_if.gnt : p1_if.gnt;
    endfunction

    function automatic logic get_rvalid(input int port);
        return (port == 0) ? p0_if.rvalid : p1_if.rvalid;
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int port);
        return (port == 0) ? p0_if.rdata : p1_if.rdata;
    endfunction

    // Starts at posedge+1 with the FSM idle (or busy for the other port); ends at posedge+1.
    task automatic access(input int port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int exp_lat,
                          input string tag, output logic [DW-1:0] rd);
        int lat = -1;
        rd = '0;
        drive(port, 1'b1, we, addr, wdata);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (get_gnt(port)) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
            drive(port, 1'b0, 1'b0, '0, '0);
            return;
        end
        if (exp_lat >= 0) check({tag, "_gnt_latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        drive(port, 1'b0, we, addr, wdata);
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(get_rvalid(port)), 32'(!we));
        if (!we) rd = get_rdata(port);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_rst_cs"}, 32'(ram_cs), 32'd0);
        check({tag, "_rst_we_oe"}, 32'({ram_we, ram_oe}), 32'd0);
        check({tag, "_rst_gnt"}, 32'({p0_if.gnt, p1_if.gnt}), 32'd0);
        check({tag, "_rst_rvalid"}, 32'({p0_if.rvalid, p1_if.rvalid}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] rd, rd0, rd1;
        int            grants[$];
        int            accesses;

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        do_reset("init");
        check("init_rdata", 32'({p0_if.rdata, p1_if.rdata}), 32'd0);

        // Write then read back on p0.
        access(0, 1'b1, 16'h0010, 8'hA5, 1, "t1_wr", rd);
        access(0, 1'b0, 16'h0010, 8'h00, 1, "t1_rd", rd);
        check("t1_rdata", 32'(rd), 32'hA5);

        // Simultaneous reads straight out of reset: p0 first, p1 three cycles later.
        access(0, 1'b1, 16'h0030, 8'h5A, 1, "t2_pre0", rd);
        access(1, 1'b1, 16'h0031, 8'hC3, 1, "t2_pre1", rd);
        do_reset("t2");
        fork
            access(0, 1'b0, 16'h0030, 8'h00, 1, "t2_p0", rd0);
            access(1, 1'b0, 16'h0031, 8'h00, 4, "t2_p1", rd1);
        join
        check("t2_p0_rdata", 32'(rd0), 32'h5A);
        check("t2_p1_rdata", 32'(rd1), 32'hC3);

        // Both ports requesting continuously: grants alternate starting with p0.
        do_reset("t3");
        drive(0, 1'b1, 1'b0, 16'h0030, 8'h00);
        drive(1, 1'b1, 1'b0, 16'h0031, 8'h00);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (p0_if.gnt) grants.push_back(0);
            if (p1_if.gnt) grants.push_back(1);
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        check("t3_grant_count", 32'(grants.size()), 32'd6);
        foreach (grants[i]) check($sformatf("t3_grant%0d", i), 32'(grants[i]), 32'(i % 2));

        // p1 writes the top address, p0 reads it; p1 rdata keeps its last read value.
        access(1, 1'b1, 16'hFFFF, 8'h3C, 1, "t4_wr", rd);
        access(0, 1'b0, 16'hFFFF, 8'h00, 1, "t4_rd", rd);
        check("t4_rdata", 32'(rd), 32'h3C);
        check("t4_p1_rdata_hold", 32'(p1_if.rdata), 32'hC3);

        // Reset asserted in the middle of a write's ACCESS cycle.
        access(0, 1'b1, 16'h0020, 8'h11, 1, "t5_pre", rd);
        drive(0, 1'b1, 1'b1, 16'h0020, 8'h77);
        @(negedge clk);
        @(posedge clk); #2;
        check("t5_cs_in_access", 32'(ram_cs), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_cs_dropped", 32'(ram_cs), 32'd0);
        check("t5_we_dropped", 32'(ram_we), 32'd0);
        check("t5_gnt_dropped", 32'(p0_if.gnt), 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_gnt", 32'(p0_if.gnt), 32'd0);
            check("t5_no_rvalid", 32'(p0_if.rvalid), 32'd0);
            @(posedge clk); #1;
        end
        access(0, 1'b0, 16'h0020, 8'h00, 1, "t5_rd", rd);
        check("t5_old_value", 32'(rd), 32'h11);

        // Mixed random traffic against a reference model; each port owns its own address parity.
        accesses = 0;
        while (accesses < 1000) begin
            int            mode;
            logic          use0, use1, we0, we1;
            logic [AW-1:0] a0, a1;
            logic [DW-1:0] wd0, wd1;
            mode = $urandom_range(0, 3);
            use0 = (mode != 1);
            use1 = (mode != 0);
            a0   = 16'h0100 + AW'(2 * $urandom_range(0, 15));
            a1   = 16'h0101 + AW'(2 * $urandom_range(0, 15));
            we0  = model.exists(a0) ? 1'($urandom_range(0, 1)) : 1'b1;
            we1  = model.exists(a1) ? 1'($urandom_range(0, 1)) : 1'b1;
            wd0  = DW'($urandom);
            wd1  = DW'($urandom);
            rd0  = '0;
            rd1  = '0;
            fork
                begin
                    if (use0) access(0, we0, a0, wd0, -1, "rand_p0", rd0);
                end
                begin
                    if (use1) access(1, we1, a1, wd1, -1, "rand_p1", rd1);
                end
            join
            if (use0) begin
                if (we0) model[a0] = wd0;
                else     check("rand_p0_rdata", 32'(rd0), 32'(model[a0]));
                accesses++;
            end
            if (use1) begin
                if (we1) model[a1] = wd1;
                else     check("rand_p1_rdata", 32'(rd1), 32'(model[a1]));
                accesses++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
